// File: rtl/instr_fetch_pkg.sv
// Shared constants for the RV32I fetch stage: default widths, NOP encoding
// and fetch FSM state encodings.
package instr_fetch_pkg;

  localparam int IWIDTH_DEF   = 32;
  localparam int PC_WIDTH_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches a fetched word arriving
// while the decoder is stalled.
module fetch_skid_buf
  import instr_fetch_pkg::*;
#(
  parameter int IWIDTH   = IWIDTH_DEF,
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic                load,
  input  logic                drain,
  input  logic                clear,
  input  logic [IWIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                vld,
  output logic [IWIDTH-1:0]   buf_instr,
  output logic [PC_WIDTH-1:0] buf_pc
);

  // Load wins over drain so a simultaneous drain+refill keeps the new word.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  always_ff @(posedge d_clk) begin
    if (load && !clear) begin
      buf_instr <= in_instr;
      buf_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues single-outstanding imem requests
// and presents {instr, pc, ce} to the decoder through a registered output.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 IWIDTH   = IWIDTH_DEF,
  parameter int                 PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                d_clk,
  input  logic                d_rst,
  output logic                f_o_imem_req,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic                f_i_imem_ack,
  input  logic [IWIDTH-1:0]   f_i_imem_data,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic                f_o_ce,
  input  logic                f_i_stall,
  input  logic                f_i_flush,
  input  logic [PC_WIDTH-1:0] f_i_flush_pc
);

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] flush_tgt;
  logic [PC_WIDTH-1:0] addr_inc;
  logic                accept;
  logic                issue_ok;
  logic                skid_vld;
  logic                skid_load;
  logic                skid_drain;
  logic [IWIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;

  assign flush_tgt = f_i_flush_pc & ~PC_WIDTH'(3);
  assign addr_inc  = f_o_imem_addr + PC_WIDTH'(4);
  assign issue_ok  = !f_i_stall && !skid_vld;

  // Only data answering a live (non-dropped, non-flushed) request is kept.
  assign accept     = f_o_imem_req && f_i_imem_ack && (state == ST_REQ) && !f_i_flush;
  assign skid_load  = accept && (f_i_stall || skid_vld);
  assign skid_drain = !f_i_stall && skid_vld;

  // Request / PC control. pc is the next address to issue; addr is frozen
  // while a request is outstanding, even across a flush.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      f_o_imem_req  <= 1'b0;
      f_o_imem_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (f_i_flush) begin
            pc            <= flush_tgt;
            f_o_imem_addr <= flush_tgt;
            f_o_imem_req  <= 1'b1;
            state         <= ST_REQ;
          end else if (issue_ok) begin
            f_o_imem_addr <= pc;
            f_o_imem_req  <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (f_i_flush) begin
            pc <= flush_tgt;
            if (f_i_imem_ack) begin
              f_o_imem_addr <= flush_tgt;
            end else begin
              state <= ST_DROP;
            end
          end else if (f_i_imem_ack) begin
            pc <= addr_inc;
            if (issue_ok) begin
              f_o_imem_addr <= addr_inc;
            end else begin
              f_o_imem_req <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (f_i_flush) begin
            pc <= flush_tgt;
          end
          if (f_i_imem_ack) begin
            f_o_imem_addr <= f_i_flush ? flush_tgt : pc;
            state         <= ST_REQ;
          end
        end
        default: begin
          f_o_imem_req <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoder-facing output register; the skid entry is always older than
  // a word accepted in the same cycle, so it goes out first.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      f_o_ce    <= 1'b0;
      f_o_instr <= IWIDTH'(NOP_INSTR);
      f_o_pc    <= '0;
    end else if (f_i_flush) begin
      f_o_ce <= 1'b0;
    end else if (!f_i_stall) begin
      if (skid_vld) begin
        f_o_instr <= skid_instr;
        f_o_pc    <= skid_pc;
        f_o_ce    <= 1'b1;
      end else if (accept) begin
        f_o_instr <= f_i_imem_data;
        f_o_pc    <= f_o_imem_addr;
        f_o_ce    <= 1'b1;
      end else begin
        f_o_ce <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(
    .IWIDTH   (IWIDTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_skid (
    .d_clk     (d_clk),
    .d_rst     (d_rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (f_i_flush),
    .in_instr  (f_i_imem_data),
    .in_pc     (f_o_imem_addr),
    .vld       (skid_vld),
    .buf_instr (skid_instr),
    .buf_pc    (skid_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder with ack budget/latency, PC
// scoreboard checked at every decoder consume, scenario tasks in sequence.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic        f_o_imem_req;
  logic [31:0] f_o_imem_addr;
  logic        f_i_imem_ack = 1'b0;
  logic [31:0] f_i_imem_data = '0;
  logic [31:0] f_o_instr;
  logic [31:0] f_o_pc;
  logic        f_o_ce;
  logic        f_i_stall = 1'b0;
  logic        f_i_flush = 1'b0;
  logic [31:0] f_i_flush_pc = '0;

  int checks = 0;
  int errors = 0;
  int ack_limit = 0;
  int acks_given = 0;
  int mem_lat = 0;
  logic [31:0] sb_q[$];

  always #5 d_clk = ~d_clk;

  instr_fetch #(
    .IWIDTH   (32),
    .PC_WIDTH (32),
    .RESET_PC (RST_PC)
  ) dut (
    .d_clk         (d_clk),
    .d_rst         (d_rst),
    .f_o_imem_req  (f_o_imem_req),
    .f_o_imem_addr (f_o_imem_addr),
    .f_i_imem_ack  (f_i_imem_ack),
    .f_i_imem_data (f_i_imem_data),
    .f_o_instr     (f_o_instr),
    .f_o_pc        (f_o_pc),
    .f_o_ce        (f_o_ce),
    .f_i_stall     (f_i_stall),
    .f_i_flush     (f_i_flush),
    .f_i_flush_pc  (f_i_flush_pc)
  );

  // Instruction memory: word at address A is ~A; acks after mem_lat wait
  // cycles while the ack budget lasts. Also watches request stability.
  initial begin
    int cnt;
    logic prev_req, prev_ack;
    logic [31:0] prev_addr;
    cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    forever begin
      @(negedge d_clk);
      if (!d_rst) begin
        f_i_imem_ack = 1'b0;
        cnt = 0;
        prev_req = 1'b0;
      end else begin
        prev_ack = f_i_imem_ack;
        if (prev_ack) cnt = 0;
        if (prev_req && !prev_ack) begin
          checks++;
          if (!f_o_imem_req || f_o_imem_addr !== prev_addr) begin
            errors++;
            $display("FAIL req_stable: got req %b addr %h, expected req 1 addr %h",
                     f_o_imem_req, f_o_imem_addr, prev_addr);
          end
        end
        if (f_o_imem_req && acks_given < ack_limit && cnt >= mem_lat) begin
          f_i_imem_ack  = 1'b1;
          f_i_imem_data = ~f_o_imem_addr;
          acks_given++;
        end else begin
          f_i_imem_ack = 1'b0;
          if (f_o_imem_req && acks_given < ack_limit) cnt++;
        end
        prev_req  = f_o_imem_req;
        prev_addr = f_o_imem_addr;
      end
    end
  end

  // Decoder side: every cycle with ce high and no stall consumes one word.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge d_clk);
      if (d_rst && f_o_ce && !f_i_stall) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL deliver_extra: got pc %h, expected no delivery", f_o_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (f_o_pc !== exp_pc) begin
            errors++;
            $display("FAIL deliver_pc: got %h, expected %h", f_o_pc, exp_pc);
          end
          checks++;
          if (f_o_instr !== ~exp_pc) begin
            errors++;
            $display("FAIL deliver_instr: got %h, expected %h", f_o_instr, ~exp_pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge d_clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic wait_ce(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (f_o_ce) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    repeat (2) step();
    checks++;
    if (f_o_imem_req !== 1'b0 || f_o_imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_req: got req %b addr %h, expected req 0 addr %h", f_o_imem_req, f_o_imem_addr, RST_PC);
    end
    checks++;
    if (f_o_ce !== 1'b0 || f_o_pc !== 32'h0 || f_o_instr !== NOP) begin
      errors++;
      $display("FAIL reset_out: got ce %b pc %h instr %h, expected ce 0 pc 0 instr %h", f_o_ce, f_o_pc, f_o_instr, NOP);
    end
    ack_limit += 3;
    for (int i = 0; i < 3; i++) sb_q.push_back(RST_PC + 32'(4 * i));
    d_rst = 1'b1;
    step();
    checks++;
    if (f_o_imem_req !== 1'b1 || f_o_imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL first_req: got req %b addr %h, expected req 1 addr %h", f_o_imem_req, f_o_imem_addr, RST_PC);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      exp = RST_PC + 32'(4 * i);
      checks++;
      if (f_o_ce !== 1'b1 || f_o_pc !== exp) begin
        errors++;
        $display("FAIL back_to_back: got ce %b pc %h, expected ce 1 pc %h", f_o_ce, f_o_pc, exp);
      end
    end
    wait_drain(40);
    checks++;
    if (sb_q.size() != 0 || f_o_imem_addr !== 32'h10C) begin
      errors++;
      $display("FAIL reset_seq_end: got pending %0d addr %h, expected 0 and 0000010c", sb_q.size(), f_o_imem_addr);
    end
  endtask

  task automatic test_flush_wait();
    f_i_flush = 1'b1;
    f_i_flush_pc = 32'h200;
    step();
    f_i_flush = 1'b0;
    checks++;
    if (f_o_ce !== 1'b0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h10C) begin
      errors++;
      $display("FAIL flush_wait: got ce %b req %b addr %h, expected ce 0 req 1 addr 0000010c", f_o_ce, f_o_imem_req, f_o_imem_addr);
    end
    ack_limit += 2;
    sb_q.push_back(32'h200);
    wait_drain(60);
    checks++;
    if (sb_q.size() != 0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL flush_wait_end: got pending %0d addr %h, expected 0 and 00000204", sb_q.size(), f_o_imem_addr);
    end
  endtask

  task automatic test_latency();
    mem_lat = 3;
    ack_limit += 4;
    for (int i = 0; i < 4; i++) sb_q.push_back(32'h204 + 32'(4 * i));
    wait_drain(100);
    mem_lat = 0;
    checks++;
    if (sb_q.size() != 0 || f_o_imem_addr !== 32'h214) begin
      errors++;
      $display("FAIL latency_end: got pending %0d addr %h, expected 0 and 00000214", sb_q.size(), f_o_imem_addr);
    end
  endtask

  task automatic test_stall();
    bit seen;
    mem_lat = 2;
    ack_limit += 3;
    sb_q.push_back(32'h214);
    sb_q.push_back(32'h218);
    sb_q.push_back(32'h21C);
    wait_ce(20, seen);
    f_i_stall = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_first: got ce 0, expected ce 1");
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (f_o_ce !== 1'b1 || f_o_pc !== 32'h214 || f_o_instr !== ~32'h214) begin
        errors++;
        $display("FAIL stall_hold: got ce %b pc %h, expected ce 1 pc 00000214", f_o_ce, f_o_pc);
      end
    end
    f_i_stall = 1'b0;
    wait_drain(60);
    mem_lat = 0;
    checks++;
    if (sb_q.size() != 0 || f_o_imem_addr !== 32'h220) begin
      errors++;
      $display("FAIL stall_end: got pending %0d addr %h, expected 0 and 00000220", sb_q.size(), f_o_imem_addr);
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    ack_limit += 1;
    wait_ce(20, seen);
    f_i_stall = 1'b1;
    f_i_flush = 1'b1;
    f_i_flush_pc = 32'h203;
    ack_limit += 1;
    step();
    f_i_flush = 1'b0;
    f_i_stall = 1'b0;
    checks++;
    if (!seen || f_o_ce !== 1'b0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL flush_stall_ack: got ce %b req %b addr %h, expected ce 0 req 1 addr 00000200", f_o_ce, f_o_imem_req, f_o_imem_addr);
    end
    ack_limit += 1;
    sb_q.push_back(32'h200);
    wait_drain(40);
    f_i_stall = 1'b1;
    ack_limit += 1;
    repeat (3) step();
    f_i_flush = 1'b1;
    f_i_flush_pc = 32'h300;
    step();
    f_i_flush = 1'b0;
    checks++;
    if (f_o_ce !== 1'b0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL flush_skid: got ce %b req %b addr %h, expected ce 0 req 1 addr 00000300", f_o_ce, f_o_imem_req, f_o_imem_addr);
    end
    f_i_stall = 1'b0;
    ack_limit += 1;
    sb_q.push_back(32'h300);
    wait_drain(40);
    checks++;
    if (sb_q.size() != 0 || f_o_imem_addr !== 32'h304) begin
      errors++;
      $display("FAIL simultaneous_end: got pending %0d addr %h, expected 0 and 00000304", sb_q.size(), f_o_imem_addr);
    end
  endtask

  task automatic test_wrap();
    f_i_flush = 1'b1;
    f_i_flush_pc = 32'hFFFF_FFF8;
    step();
    f_i_flush = 1'b0;
    ack_limit += 4;
    sb_q.push_back(32'hFFFF_FFF8);
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0000_0000);
    wait_drain(60);
    checks++;
    if (sb_q.size() != 0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL wrap: got pending %0d req %b addr %h, expected 0, 1, 00000004", sb_q.size(), f_o_imem_req, f_o_imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    ack_limit += 1;
    wait_ce(20, seen);
    f_i_stall = 1'b1;
    #3;
    d_rst = 1'b0;
    #1;
    checks++;
    if (!seen || f_o_imem_req !== 1'b0 || f_o_ce !== 1'b0 || f_o_imem_addr !== RST_PC ||
        f_o_pc !== 32'h0 || f_o_instr !== NOP) begin
      errors++;
      $display("FAIL reset_mid: got req %b ce %b addr %h pc %h instr %h, expected 0 0 %h 0 %h",
               f_o_imem_req, f_o_ce, f_o_imem_addr, f_o_pc, f_o_instr, RST_PC, NOP);
    end
    f_i_stall = 1'b0;
    repeat (2) step();
    d_rst = 1'b1;
    step();
    checks++;
    if (f_o_imem_req !== 1'b1 || f_o_imem_addr !== RST_PC || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: got req %b addr %h pending %0d, expected 1 %h 0", f_o_imem_req, f_o_imem_addr, sb_q.size(), RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_flush_wait();
    test_latency();
    test_stall();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
